// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned ADJ_THRESH = 5;
  localparam int unsigned ADJ_ADD    = 3;
  localparam logic [6:0]  SEG_BLANK  = 7'b0;

  // Decimal digits needed for a WIDTH-bit value: ceil(width * log10(2)).
  function automatic int unsigned digits_needed(input int unsigned width);
    longint unsigned prod;
    prod = 64'(width) * 64'd30103;
    return 32'((prod + 64'd99999) / 64'd100000);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-high {g,f,e,d,c,b,a} segment decoder.
module seg7_decode
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [6:0]         o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg_c = 7'h3F;
      4'd1:    o_seg_c = 7'h06;
      4'd2:    o_seg_c = 7'h5B;
      4'd3:    o_seg_c = 7'h4F;
      4'd4:    o_seg_c = 7'h66;
      4'd5:    o_seg_c = 7'h6D;
      4'd6:    o_seg_c = 7'h7D;
      4'd7:    o_seg_c = 7'h07;
      4'd8:    o_seg_c = 7'h7F;
      4'd9:    o_seg_c = 7'h6F;
      default: o_seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Double-dabble binary-to-BCD converter, one bit per cycle, start/done handshake.
// Define SEG7_EN to add the registered 7-segment output port seg.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WIDTH-1:0]            bin,
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*DIGITS-1:0]   bcd
`ifdef SEG7_EN
  ,
  output logic [7*DIGITS-1:0]         seg
`endif
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  if (DIGITS < digits_needed(WIDTH)) begin : g_digits_check
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_bin;
  logic [BCD_W-1:0]   r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_work_sh;
  logic [WIDTH-1:0]   w_bin_sh;
  logic               w_last;
  logic               w_accept;

  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

  // Add-3 correction on every digit that is 5 or more; digits never carry.
  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (r_work[d*DIGIT_W +: DIGIT_W] >= DIGIT_W'(ADJ_THRESH))
        w_adj[d*DIGIT_W +: DIGIT_W] = r_work[d*DIGIT_W +: DIGIT_W] + DIGIT_W'(ADJ_ADD);
    end
  end

  assign {w_work_sh, w_bin_sh} = {w_adj, r_bin} << 1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_work <= '0;
      r_cnt  <= '0;
      r_bcd  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == SHIFT);
      r_done <= (w_next == DONE);
      if (w_accept) begin
        r_bin  <= bin;
        r_work <= '0;
        r_cnt  <= '0;
      end else if (r_state == SHIFT) begin
        r_bin  <= w_bin_sh;
        r_work <= w_work_sh;
        r_cnt  <= r_cnt + CNT_W'(1);
        if (w_last) r_bcd <= w_work_sh;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

`ifdef SEG7_EN
  logic [7*DIGITS-1:0] w_seg;
  logic [7*DIGITS-1:0] r_seg;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
    seg7_decode u_dec (
      .i_digit (w_work_sh[g*DIGIT_W +: DIGIT_W]),
      .o_seg_c (w_seg[g*7 +: 7])
    );
  end

  // Segments load alongside bcd; reset leaves the display blank.
  always_ff @(posedge clk) begin
    if (rst)                           r_seg <= '0;
    else if ((r_state == SHIFT) && w_last) r_seg <= w_seg;
  end

  assign seg = r_seg;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: driver queues expected results, monitor checks on done.
module tb_bin2bcd_seq;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin   = 8'd0;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
`ifdef SEG7_EN
  logic [20:0] seg;
`endif

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
`ifdef SEG7_EN
    ,
    .seg   (seg)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  logic        rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  typedef struct {
    logic [11:0] bcd;
    int unsigned cyc;
    logic [7:0]  val;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal digits by plain division.
  function automatic logic [11:0] ref_bcd(input int unsigned v);
    logic [11:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < int'(DIGITS); d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

`ifdef SEG7_EN
  function automatic logic [20:0] ref_seg(input int unsigned v);
    logic [6:0]  glyph [10];
    logic [20:0] s;
    int unsigned x;
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    s = '0;
    x = v;
    for (int d = 0; d < int'(DIGITS); d++) begin
      s[d*7 +: 7] = glyph[x % 10];
      x = x / 10;
    end
    return s;
  endfunction
  logic [20:0] exp_seg_hold = '0;
`endif

  logic [11:0] exp_hold = '0;
  exp_t        e;

  // Monitor: pops on done, checks latency/value, and that outputs hold between results.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) begin
        q.delete();
        exp_hold = '0;
`ifdef SEG7_EN
        exp_seg_hold = '0;
`endif
      end
      if (done) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_done: got done=1 expected no pending conversion (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check($sformatf("bcd(bin=%0d)", e.val), {20'd0, bcd}, {20'd0, e.bcd});
          exp_hold = e.bcd;
`ifdef SEG7_EN
          exp_seg_hold = ref_seg(e.val);
          check($sformatf("seg(bin=%0d)", e.val), {11'd0, seg}, {11'd0, exp_seg_hold});
`endif
        end
      end else if (q.size() != 0 && cyc > q[0].cyc) begin
        e = q.pop_front();
        check($sformatf("done_missing(bin=%0d)", e.val), 32'(done), 32'd1);
      end
      check("bcd_hold", {20'd0, bcd}, {20'd0, exp_hold});
`ifdef SEG7_EN
      check("seg_hold", {11'd0, seg}, {11'd0, exp_seg_hold});
`endif
      check("busy_and_done", 32'(busy && done), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] v);
    start = 1'b1;
    bin   = v;
    q.push_back('{ref_bcd(v), cyc + WIDTH + 1, v});
  endtask

  // One conversion; optional noise on bin/start while shifting, then idle gap.
  task automatic convert(input logic [7:0] v, input int gap, input bit noise);
    issue(v);
    tick();
    start = 1'b0;
    repeat (WIDTH) begin
      if (noise) begin
        bin   = 8'($urandom);
        start = 1'($urandom_range(0, 1));
      end
      tick();
    end
    start = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    logic [7:0] directed [8];
    directed = '{8'd0, 8'd99, 8'd100, 8'd9, 8'd10, 8'd90, 8'd199, 8'd88};

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // Quiet after reset.
    repeat (5) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_bcd", {20'd0, bcd}, 32'd0);
      tick();
    end

    // Max value with explicit busy window and single done pulse.
    issue(8'hFF);
    tick();
    start = 1'b0;
    for (int i = 1; i <= int'(WIDTH); i++) begin
      @(negedge clk);
      check($sformatf("ff_busy_c%0d", i), 32'(busy), 32'd1);
      check($sformatf("ff_done_c%0d", i), 32'(done), 32'd0);
      tick();
    end
    @(negedge clk);
    check("ff_busy_done_cycle", 32'(busy), 32'd0);
    check("ff_done_pulse", 32'(done), 32'd1);
    check("ff_bcd", {20'd0, bcd}, 32'h255);
    tick();
    @(negedge clk);
    check("ff_done_one_cycle", 32'(done), 32'd0);
    repeat (3) tick();

    foreach (directed[i]) convert(directed[i], 1, 1'b0);

    // Back-to-back: start held, new operand presented in the DONE cycle.
    issue(8'd37);
    repeat (WIDTH + 1) tick();
    issue(8'd200);
    tick();
    start = 1'b0;
    repeat (WIDTH + 2) tick();

    // start pulse and operand change mid-conversion are ignored.
    issue(8'd123);
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1;
    bin   = 8'd45;
    tick();
    start = 1'b0;
    bin   = 8'd77;
    repeat (6) tick();

    // Reset in the middle of a conversion aborts it with no done.
    issue(8'd200);
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", {20'd0, bcd}, 32'd0);
    repeat (12) tick();

    // Every input value, with random gaps and noise during the shift.
    for (int v = 0; v < 256; v++) convert(8'(v), $urandom_range(0, 2), 1'b1);

    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    check("drain_pending", 32'(q.size()), 32'd0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per cycle. It consumes the binary count produced by the lab counters and delivers packed BCD digits for the decimal/7-segment display path. A start/done handshake lets the counter side request a conversion and hold the result stable between conversions.

Parameters:
WIDTH, 8, width of the binary input.
DIGITS, 3, number of BCD output digits. Must satisfy DIGITS >= ceil(WIDTH*log10(2)); elaboration fails otherwise.

Ports:
clk  input  1  clock, all state updates on posedge.
rst  input  1  reset, synchronous, active-high.
start  input  1  conversion request, sampled when the FSM is in IDLE or DONE.
bin  input  WIDTH  binary value, captured on the edge that accepts start.
busy  output  1  high while the FSM is in SHIFT.
done  output  1  one-cycle pulse, high while the FSM is in DONE.
bcd  output  4*DIGITS  packed BCD result, digit 0 in [3:0]; valid from done onward and held until the next done.

Behaviour:
- Reset (rst=1 at posedge) forces state IDLE and clears all registers: bcd=0, busy=0, done=0, shift/work registers=0, iteration counter=0. This takes priority over any other activity, including a conversion in progress. No partial result appears on bcd.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start=1, latch bin into the binary shift register, clear the BCD work register and the iteration counter, then go to SHIFT. Otherwise stay in IDLE.
- SHIFT: each cycle performs one iteration:
  - For every 4-bit digit of the work register >= 5, add 3. Each digit is 4 bits; there is no carry between digits.
  - Shift {work, binshift} left by 1. The MSB of binshift enters work[0].
  - Increment the iteration counter, which is $clog2(WIDTH+1) bits wide.
  - On the WIDTH-th iteration, load bcd with the post-shift work value and go to DONE.
  - start is ignored in SHIFT; a conversion cannot be aborted except by rst.
- DONE: done=1 for exactly this cycle.
  - If start=1, accept a new conversion with the same actions as IDLE, go to SHIFT.
  - Otherwise go to IDLE.
- Latency: start high in cycle c (accepted) gives done high in cycle c+WIDTH+1.
- Throughput: back-to-back conversions complete every WIDTH+1 cycles.
- bin is a don't-care except on the accepting edge. Changes to bin during SHIFT do not affect the result.
- bcd changes only on the edge entering DONE (or on rst).
- busy and done are never high together. In IDLE both are 0.

Optional Feature:
SEG7_EN
- Defined: adds output port seg, 7*DIGITS wide. It holds per-digit active-high segments {g,f,e,d,c,b,a}, digit 0 in [6:0].
  - Digit values 0-9 map to the standard glyphs; values 10-15 cannot occur and drive all segments off.
  - seg is registered and updates on the same edge as bcd. seg is 0 after reset, which blanks the display. It does not read as a decoded 0.
- Not defined: the seg port and its decode logic are absent. Other behaviour is identical.

Decomposition:
- Package bin2bcd_pkg:
  - state_t enum {IDLE, SHIFT, DONE}.
  - Constant DIGIT_W=4.
  - Constant ADJ_THRESH=5, ADJ_ADD=3.
  - Constant SEG_BLANK=7'b0.
  - Function digits_needed(width), used in the elaboration check.
- Sub-module seg7_decode: combinational 4-bit to 7-segment decoder, instantiated DIGITS times under SEG7_EN. The segment output register lives in bin2bcd_seq.

Test Plan (WIDTH=8, DIGITS=3):
- rst for 2 cycles, then idle 5 cycles -> bcd=12'h000, busy=0, done=0 throughout (seg=0 if SEG7_EN).
- start=1 for 1 cycle with bin=8'hFF in cycle c -> busy=1 in cycles c+1..c+8, done=1 only in c+9, bcd=12'h255 from c+9 and held.
- bin=8'd0 -> bcd=12'h000. bin=8'd99 -> bcd=12'h099. bin=8'd100 -> bcd=12'h100. Check each digit boundary.
- Back-to-back: start held high with bin=8'd37, then bin=8'd200 applied in the DONE cycle -> done pulses 9 cycles apart, bcd=12'h037 then 12'h200.
- start pulsed and bin changed mid-SHIFT -> ignored, result matches the value latched at acceptance. rst asserted at iteration 4 -> next cycle IDLE, bcd=0, no done pulse.
- Exhaustive 0..255 against a reference model; SEG7_EN build -> seg for 8'd88 equals {7'h7F,7'h7F} on digits 1:0 and 7'h3F on digit 2.
